// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flop-based FIFO: full-policy enum,
// pointer wrap function and the default occupancy counter width.
package fifo_pkg;

  typedef enum logic {
    DROP_NEW         = 1'b0,
    OVERWRITE_OLDEST = 1'b1
  } fifo_mode_e;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_DEPTH + 1);

  // Explicit wrap so depths that are not a power of two still cycle 0..depth-1.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and sticky-error bookkeeping for fifo_flops_v2.
// Decides which push/pop requests are accepted and tells the storage when to write/read.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int         depth = 8,
  parameter fifo_mode_e MODE  = DROP_NEW,
  parameter int         PW    = $clog2(depth),
  parameter int         CW    = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic          wr_en,
  output logic          rd_en,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  // push/pop are single-cycle requests with no backpressure: a request is
  // acted on at the edge where it is high, or reported via overflow/underflow.
  logic is_empty;
  logic is_full;
  logic overwrite;
  logic ovf_evt;
  logic unf_evt;
  logic cnt_inc;
  logic cnt_dec;

  always_comb begin
    is_empty  = (count == '0);
    is_full   = (count == CW'(depth));
    rd_en     = pop && !is_empty;
    overwrite = push && !pop && is_full && (MODE == OVERWRITE_OLDEST);
    wr_en     = push && (!is_full || pop || (MODE == OVERWRITE_OLDEST));
    ovf_evt   = push && !pop && is_full;
    unf_evt   = pop && is_empty;
    cnt_inc   = wr_en && !rd_en && !overwrite;
    cnt_dec   = rd_en && !wr_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= PW'(ptr_next(int'(wr_ptr), depth));
      // Overwriting the oldest slot retires it, so the read side moves too.
      if (rd_en || overwrite) rd_ptr <= PW'(ptr_next(int'(rd_ptr), depth));
      if (cnt_inc)      count <= count + 1'b1;
      else if (cnt_dec) count <= count - 1'b1;
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

endmodule

// File: rtl/fifo_flops_v2.sv
// Flop-array FIFO with registered read data, occupancy count, threshold flags,
// sticky overflow/underflow and a selectable full policy.
module fifo_flops_v2
  import fifo_pkg::*;
#(
  parameter int bits   = 16,
  parameter int depth  = 8,
  parameter int MODE   = 0,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [bits-1:0]            Din,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr_err,
  output logic [bits-1:0]            Dout,
  output logic                       full,
  output logic                       pndng,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int         PW     = $clog2(depth);
  localparam int         CW     = $clog2(depth + 1);
  localparam fifo_mode_e POLICY = (MODE == 1) ? OVERWRITE_OLDEST : DROP_NEW;

  logic [bits-1:0] mem [depth];
  logic            wr_en;
  logic            rd_en;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  fifo_ptr_ctrl #(
    .depth (depth),
    .MODE  (POLICY),
    .PW    (PW),
    .CW    (CW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clr_err   (clr_err),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= Din;
  end

  // On push+pop at full rd_ptr == wr_ptr; the read sees the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       Dout <= '0;
    else if (rd_en) Dout <= mem[rd_ptr];
  end

  always_comb begin
    full         = (count == CW'(depth));
    pndng        = (count != '0);
    almost_full  = (count >= CW'(AF_LVL));
    almost_empty = (count <= CW'(AE_LVL));
  end

endmodule
